reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
Consumes the clock and the raw reset delivered by the clock block. Produces sequenced, synchronously released reset lines for the core, memory and peripherals. Reset assertion is asynchronous. Release waits for PLL lock and a stretch interval, then frees each stage in order with a fixed gap. Also handles software-requested resets and PLL lock loss, and records the cause of the last reset.

Parameters:
SYNC_STAGES, 2, flops in the reset-release synchronizer and in the pll_locked synchronizer (min 2)
STRETCH_CYCLES, 16, cycles held in reset after lock is seen (min 1)
NUM_STAGES, 3, number of staged reset outputs (1..8)
STAGE_GAP, 4, cycles between consecutive stage releases (min 1)
WDOG_CYCLES, 1024, watchdog timeout in cycles (used only with the optional feature)

Ports:
clk  in  1  design clock
reset  in  1  asynchronous, active-high reset
pll_locked  in  1  PLL lock indication, asynchronous to clk
sw_reset_req  in  1  single-cycle software reset request
wdog_kick  in  1  watchdog refresh pulse
rst_out  out  NUM_STAGES  active-high resets; bit 0 released first
ready  out  1  high when all stages are released
reset_cause  out  2  0 = pin, 1 = PLL lock loss, 2 = software, 3 = watchdog

Behaviour:
- Assertion of reset:
  - Immediately and asynchronously sets rst_out to all ones, ready to 0 and reset_cause to 0.
  - Clears all counters and the synchronizers; FSM enters SYNC.
- Release: deassertion passes through a SYNC_STAGES-flop synchronizer. No output changes until the synchronizer output falls.
- pll_locked is always sampled through its own SYNC_STAGES-flop synchronizer (lock_s).
- FSM states and transitions:
  - SYNC: on synchronizer release -> WAIT_LOCK.
  - WAIT_LOCK: when lock_s = 1 -> STRETCH, counter = 0.
  - STRETCH: counter increments each cycle. After exactly STRETCH_CYCLES cycles in STRETCH -> RELEASE, stage index = 0, gap counter = 0.
  - RELEASE:
    - rst_out[0] clears on the first RELEASE cycle.
    - Each following stage clears STAGE_GAP cycles after the previous one.
    - On the cycle the last stage clears, ready rises in the same cycle and the FSM enters RUN.
  - RUN: all outputs released; waits for a reset event.
- Reset events in WAIT_LOCK, STRETCH, RELEASE or RUN:
  - lock_s falling -> reset_cause = 1.
  - sw_reset_req = 1 -> reset_cause = 2.
  - Effect of any event, on the next clock edge: rst_out = all ones, ready = 0, FSM -> WAIT_LOCK.
- Simultaneous events: lock loss takes priority over software, which takes priority over watchdog. reset_cause records only the winner.
- reset_cause changes only on an event or on pin reset; it stays valid through the following release.
- Stage bits clear monotonically (bit i never clears before bit i-1). Once cleared, a bit is re-set only by a full re-entry to reset.
- An event during RELEASE aborts the sequence; no partially released state persists.
- sw_reset_req in SYNC is ignored.
- Counter widths are $clog2 of (max(STRETCH_CYCLES, STAGE_GAP, WDOG_CYCLES) + 1). No wrap occurs.

Optional Feature:
Macro RESET_SEQ_WDOG_EN.
- Defined:
  - A watchdog counter runs only in RUN.
  - It clears on wdog_kick and on entry to RUN.
  - When it reaches WDOG_CYCLES without a kick, it raises a reset event with reset_cause = 3.
  - A kick in the same cycle as the timeout wins: no reset occurs.
- Undefined: wdog_kick is ignored, no watchdog logic is built, and reset_cause never equals 3.

Test Plan:
1. Pin reset, pll_locked = 1 throughout, defaults; release reset -> after 2 sync cycles + 16 stretch cycles, rst_out steps 3'b111 -> 3'b110 -> (4 cycles) 3'b100 -> (4 cycles) 3'b000; ready rises with the last step; reset_cause = 0.
2. pll_locked low at release, raised 50 cycles later -> rst_out stays 3'b111 until 2 + 16 cycles after lock is raised, then the sequence from scenario 1.
3. In RUN, pulse sw_reset_req for 1 cycle -> next edge rst_out = 3'b111, ready = 0, reset_cause = 2; full re-sequence follows.
4. Drop pll_locked during RELEASE while rst_out = 3'b100, with sw_reset_req the same cycle lock_s falls -> rst_out = 3'b111, reset_cause = 1; stays in WAIT_LOCK until lock returns.
5. Assert reset mid-STRETCH, asynchronously between clock edges -> rst_out = all ones and reset_cause = 0 before the next edge; counters restart from 0 after release.
6. With RESET_SEQ_WDOG_EN, WDOG_CYCLES = 8:
   - no kick for 8 RUN cycles -> reset event with reset_cause = 3;
   - kick on cycle 8 -> no reset.
   - Without the macro, no reset after 10000 cycles.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: turns the raw pin reset into staged, synchronously released
// reset lines (bit 0 first), gated on PLL lock plus a stretch interval.
// Software requests and PLL lock loss restart the sequence, and the cause of
// the most recent reset is kept on reset_cause.
// Optional watchdog: define RESET_SEQ_WDOG_EN to build it.
// Release latency from pin deassertion: SYNC_STAGES synchronizer edges, one
// SYNC->WAIT_LOCK edge, one WAIT_LOCK->STRETCH edge, then STRETCH_CYCLES.

module reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int NUM_STAGES     = 3,
    parameter int STAGE_GAP      = 4,
    parameter int WDOG_CYCLES    = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pll_locked,
    input  logic                  sw_reset_req,
    input  logic                  wdog_kick,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic [1:0]            reset_cause
);

    localparam int MAX_SG  = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
    localparam int MAX_ALL = (MAX_SG > WDOG_CYCLES) ? MAX_SG : WDOG_CYCLES;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    localparam logic [1:0] CAUSE_PIN  = 2'd0;
    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_SW   = 2'd2;
    localparam logic [1:0] CAUSE_WDOG = 2'd3;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_WAIT_LOCK,
        ST_STRETCH,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  rst_sync_q, rst_sync_d;
    logic [SYNC_STAGES-1:0]  lock_sync_q, lock_sync_d;
    logic                    lock_prev_q, lock_prev_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        gap_q, gap_d;
    logic [NUM_STAGES-1:0]   rst_q, rst_d;
    logic                    ready_q, ready_d;
    logic [1:0]              cause_q, cause_d;

    logic lock_s;
    logic released;
    logic ev_lock;
    logic ev_sw;
    logic ev_wdog;

    assign lock_s   = lock_sync_q[SYNC_STAGES-1];
    assign released = ~rst_sync_q[SYNC_STAGES-1];
    assign ev_lock  = lock_prev_q & ~lock_s;
    assign ev_sw    = sw_reset_req;

    // Shift a zero into the release synchronizer and the raw lock into its own
    always_comb begin
        rst_sync_d  = {rst_sync_q[SYNC_STAGES-2:0], 1'b0};
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
        lock_prev_d = lock_s;
    end

    // Synchronizer flops: pin reset holds release pending and forgets any lock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_sync_q  <= '1;
            lock_sync_q <= '0;
            lock_prev_q <= 1'b0;
        end else begin
            rst_sync_q  <= rst_sync_d;
            lock_sync_q <= lock_sync_d;
            lock_prev_q <= lock_prev_d;
        end
    end

`ifdef RESET_SEQ_WDOG_EN
    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             wdog_timeout;

    assign wdog_timeout = (state_q == ST_RUN) && !wdog_kick
                          && (wdog_q == CNT_W'(WDOG_CYCLES - 1));
    assign ev_wdog      = wdog_timeout;

    // Watchdog counts RUN cycles only; it sits at zero outside RUN so RUN entry starts fresh
    always_comb begin
        wdog_d = wdog_q;
        if (state_q != ST_RUN || wdog_kick || wdog_timeout) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic unused_wdog_kick;
    assign unused_wdog_kick = wdog_kick;
    assign ev_wdog          = 1'b0;
`endif

    // Next-state logic: normal sequencing first, then any reset event overrides it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        cause_d = cause_q;

        case (state_q)
            ST_SYNC: begin
                if (released) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STRETCH;
                    cnt_d   = '0;
                end
            end
            ST_STRETCH: begin
                if (cnt_q == CNT_W'(STRETCH_CYCLES - 1)) begin
                    gap_d = '0;
                    rst_d = rst_q << 1;
                    if (rst_d == '0) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (gap_q == CNT_W'(STAGE_GAP - 1)) begin
                    gap_d = '0;
                    rst_d = rst_q << 1;
                    if (rst_d == '0) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase

        if (state_q != ST_SYNC && (ev_lock || ev_sw || ev_wdog)) begin
            state_d = ST_WAIT_LOCK;
            rst_d   = '1;
            ready_d = 1'b0;
            cnt_d   = '0;
            gap_d   = '0;
            if (ev_lock) begin
                cause_d = CAUSE_LOCK;
            end else if (ev_sw) begin
                cause_d = CAUSE_SW;
            end else begin
                cause_d = CAUSE_WDOG;
            end
        end
    end

    // Sequencer state register; pin reset asserts every output at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
            gap_q   <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            cause_q <= CAUSE_PIN;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            cause_q <= cause_d;
        end
    end

    assign rst_out     = rst_q;
    assign ready       = ready_q;
    assign reset_cause = cause_q;

endmodule
